// File: rtl/stopwatch_control.sv
// rtl/stopwatch_control.sv - run/stop/clear stopwatch FSM with centisecond prescaler and hh:mm:ss.cc counters
module stopwatch_control #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int TICK_HZ  = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_btn_run_stop,
  input  logic       i_btn_clear,
  input  logic       i_btn_run_md,
  output logic [6:0] o_msec,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_running,
  output logic       o_mode
);

  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [6:0]    msec_q, msec_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [4:0]    hour_q, hour_d;
  logic          running_q, running_d;
  logic          mode_q, mode_d;
  // armed_q stays low through the reset-release edge so buttons on that edge are dropped
  logic          armed_q, armed_d;

  logic run_stop_v, clear_v, run_md_v, tick;

  // Qualify buttons and derive the centisecond tick from the prescaler
  always_comb begin
    run_stop_v = i_btn_run_stop & armed_q;
    clear_v    = i_btn_clear & armed_q;
    run_md_v   = i_btn_run_md & armed_q;
    tick       = (state_q == ST_RUN) && (presc_q == PRESC_MAX);
    armed_d    = 1'b1;
  end

  // Next-state logic: clear has priority over run/stop in STOP; CLEAR always lasts one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP: begin
        if (clear_v)         state_d = ST_CLEAR;
        else if (run_stop_v) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (run_stop_v) state_d = ST_STOP;
      end
      ST_CLEAR: state_d = ST_STOP;
      default:  state_d = ST_STOP;
    endcase
    running_d = (state_d == ST_RUN);
    mode_d    = mode_q ^ run_md_v;
  end

  // Prescaler and cascaded time counters; all carries resolve on the same edge
  always_comb begin
    presc_d = presc_q;
    msec_d  = msec_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    if (state_q == ST_CLEAR) begin
      presc_d = '0;
      msec_d  = '0;
      sec_d   = '0;
      min_d   = '0;
      hour_d  = '0;
    end else if (state_q == ST_RUN) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        if (msec_q == 7'd99) begin
          msec_d = '0;
          if (sec_q == 6'd59) begin
            sec_d = '0;
            if (min_q == 6'd59) begin
              min_d  = '0;
              hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end else begin
          msec_d = msec_q + 7'd1;
        end
      end
    end
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_STOP;
      presc_q   <= '0;
      msec_q    <= '0;
      sec_q     <= '0;
      min_q     <= '0;
      hour_q    <= '0;
      running_q <= 1'b0;
      mode_q    <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      msec_q    <= msec_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      hour_q    <= hour_d;
      running_q <= running_d;
      mode_q    <= mode_d;
      armed_q   <= armed_d;
    end
  end

  assign o_msec    = msec_q;
  assign o_sec     = sec_q;
  assign o_min     = min_q;
  assign o_hour    = hour_q;
  assign o_running = running_q;
  assign o_mode    = mode_q;

endmodule

// File: tb/tb_stopwatch_control.sv
// tb/tb_stopwatch_control.sv - directed self-checking bench for stopwatch_control (DIV = 10)
module tb_stopwatch_control;

  logic       clk;
  logic       reset;
  logic       i_btn_run_stop;
  logic       i_btn_clear;
  logic       i_btn_run_md;
  logic [6:0] o_msec;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hour;
  logic       o_running;
  logic       o_mode;

  int checks = 0;
  int errors = 0;

  stopwatch_control #(.CLK_FREQ(1000), .TICK_HZ(100)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_btn_run_stop (i_btn_run_stop),
    .i_btn_clear    (i_btn_clear),
    .i_btn_run_md   (i_btn_run_md),
    .o_msec         (o_msec),
    .o_sec          (o_sec),
    .o_min          (o_min),
    .o_hour         (o_hour),
    .o_running      (o_running),
    .o_mode         (o_mode)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a button combination for exactly one rising edge
  task automatic pulse(input logic rs, input logic clr, input logic md);
    i_btn_run_stop = rs;
    i_btn_clear    = clr;
    i_btn_run_md   = md;
    @(negedge clk);
    i_btn_run_stop = 1'b0;
    i_btn_clear    = 1'b0;
    i_btn_run_md   = 1'b0;
  endtask

  task automatic test_reset;
    cycles(2);
    checks++; if (o_msec !== 7'd0)    begin errors++; $display("FAIL reset_msec: got %0d expected 0", o_msec); end
    checks++; if (o_sec !== 6'd0)     begin errors++; $display("FAIL reset_sec: got %0d expected 0", o_sec); end
    checks++; if (o_min !== 6'd0)     begin errors++; $display("FAIL reset_min: got %0d expected 0", o_min); end
    checks++; if (o_hour !== 5'd0)    begin errors++; $display("FAIL reset_hour: got %0d expected 0", o_hour); end
    checks++; if (o_running !== 1'b0) begin errors++; $display("FAIL reset_running: got %0b expected 0", o_running); end
    checks++; if (o_mode !== 1'b0)    begin errors++; $display("FAIL reset_mode: got %0b expected 0", o_mode); end
    // buttons held across the release edge must be ignored
    i_btn_run_stop = 1'b1;
    i_btn_run_md   = 1'b1;
    #3 reset = 1'b1;
    @(negedge clk);
    i_btn_run_stop = 1'b0;
    i_btn_run_md   = 1'b0;
    checks++; if (o_running !== 1'b0) begin errors++; $display("FAIL release_running: got %0b expected 0", o_running); end
    checks++; if (o_mode !== 1'b0)    begin errors++; $display("FAIL release_mode: got %0b expected 0", o_mode); end
    cycles(20);
    checks++; if (o_msec !== 7'd0)    begin errors++; $display("FAIL release_msec: got %0d expected 0", o_msec); end
  endtask

  task automatic test_run_one_second;
    pulse(1, 0, 0);
    checks++; if (o_running !== 1'b1) begin errors++; $display("FAIL run_entry_running: got %0b expected 1", o_running); end
    cycles(1000);
    checks++; if (o_running !== 1'b1) begin errors++; $display("FAIL run1s_running: got %0b expected 1", o_running); end
    checks++; if (o_sec !== 6'd1)     begin errors++; $display("FAIL run1s_sec: got %0d expected 1", o_sec); end
    checks++; if (o_msec !== 7'd0)    begin errors++; $display("FAIL run1s_msec: got %0d expected 0", o_msec); end
    pulse(1, 0, 0);
    checks++; if (o_running !== 1'b0) begin errors++; $display("FAIL stop_running: got %0b expected 0", o_running); end
    pulse(0, 1, 0);
    cycles(1);
    checks++; if (o_sec !== 6'd0)     begin errors++; $display("FAIL clear_sec: got %0d expected 0", o_sec); end
  endtask

  task automatic test_phase_resume;
    pulse(1, 0, 0);
    cycles(24);
    pulse(1, 0, 0);
    cycles(500);
    checks++; if (o_msec !== 7'd2)    begin errors++; $display("FAIL hold_msec: got %0d expected 2", o_msec); end
    checks++; if (o_running !== 1'b0) begin errors++; $display("FAIL hold_running: got %0b expected 0", o_running); end
    pulse(1, 0, 0);
    cycles(4);
    checks++; if (o_msec !== 7'd2)    begin errors++; $display("FAIL resume4_msec: got %0d expected 2", o_msec); end
    cycles(1);
    checks++; if (o_msec !== 7'd3)    begin errors++; $display("FAIL resume5_msec: got %0d expected 3", o_msec); end
    // stop on the very edge where a tick is due: tick must still land
    cycles(9);
    pulse(1, 0, 0);
    checks++; if (o_msec !== 7'd4)    begin errors++; $display("FAIL stop_on_tick_msec: got %0d expected 4", o_msec); end
    checks++; if (o_running !== 1'b0) begin errors++; $display("FAIL stop_on_tick_running: got %0b expected 0", o_running); end
  endtask

  task automatic test_clear_priority;
    pulse(1, 1, 0);
    checks++; if (o_running !== 1'b0) begin errors++; $display("FAIL clr_cycle_running: got %0b expected 0", o_running); end
    cycles(1);
    checks++; if (o_msec !== 7'd0)    begin errors++; $display("FAIL clr_msec: got %0d expected 0", o_msec); end
    checks++; if (o_running !== 1'b0) begin errors++; $display("FAIL clr_running: got %0b expected 0", o_running); end
    cycles(20);
    checks++; if (o_msec !== 7'd0)    begin errors++; $display("FAIL clr_stays_stop: got %0d expected 0", o_msec); end
    // clear during RUN has no effect on counters or prescaler
    pulse(1, 0, 0);
    cycles(14);
    pulse(0, 1, 0);
    checks++; if (o_running !== 1'b1) begin errors++; $display("FAIL run_clr_running: got %0b expected 1", o_running); end
    checks++; if (o_msec !== 7'd1)    begin errors++; $display("FAIL run_clr_msec: got %0d expected 1", o_msec); end
    cycles(5);
    checks++; if (o_msec !== 7'd2)    begin errors++; $display("FAIL run_clr_phase: got %0d expected 2", o_msec); end
    pulse(1, 0, 0);
    pulse(0, 1, 0);
    cycles(1);
  endtask

  task automatic test_mode;
    pulse(0, 0, 1);
    checks++; if (o_mode !== 1'b1)    begin errors++; $display("FAIL mode_stop: got %0b expected 1", o_mode); end
    pulse(1, 0, 0);
    cycles(3);
    pulse(0, 0, 1);
    checks++; if (o_mode !== 1'b0)    begin errors++; $display("FAIL mode_run: got %0b expected 0", o_mode); end
    checks++; if (o_msec !== 7'd0)    begin errors++; $display("FAIL mode_run_msec: got %0d expected 0", o_msec); end
    pulse(1, 0, 0);
    pulse(0, 1, 0);
    // mode and run/stop together while in CLEAR: mode toggles, run/stop dropped
    pulse(1, 0, 1);
    checks++; if (o_mode !== 1'b1)    begin errors++; $display("FAIL mode_clear: got %0b expected 1", o_mode); end
    checks++; if (o_running !== 1'b0) begin errors++; $display("FAIL mode_clear_running: got %0b expected 0", o_running); end
    cycles(20);
    checks++; if (o_msec !== 7'd0)    begin errors++; $display("FAIL mode_clear_msec: got %0d expected 0", o_msec); end
    checks++; if (o_running !== 1'b0) begin errors++; $display("FAIL mode_clear_idle: got %0b expected 0", o_running); end
  endtask

  task automatic test_rollover;
    force dut.msec_q = 7'd99;
    force dut.sec_q  = 6'd59;
    force dut.min_q  = 6'd59;
    force dut.hour_q = 5'd23;
    cycles(1);
    release dut.msec_q;
    release dut.sec_q;
    release dut.min_q;
    release dut.hour_q;
    cycles(1);
    pulse(1, 0, 0);
    cycles(9);
    checks++; if (o_msec !== 7'd99)   begin errors++; $display("FAIL roll_pre_msec: got %0d expected 99", o_msec); end
    checks++; if (o_hour !== 5'd23)   begin errors++; $display("FAIL roll_pre_hour: got %0d expected 23", o_hour); end
    cycles(1);
    checks++; if (o_msec !== 7'd0)    begin errors++; $display("FAIL roll_msec: got %0d expected 0", o_msec); end
    checks++; if (o_sec !== 6'd0)     begin errors++; $display("FAIL roll_sec: got %0d expected 0", o_sec); end
    checks++; if (o_min !== 6'd0)     begin errors++; $display("FAIL roll_min: got %0d expected 0", o_min); end
    checks++; if (o_hour !== 5'd0)    begin errors++; $display("FAIL roll_hour: got %0d expected 0", o_hour); end
    checks++; if (o_running !== 1'b1) begin errors++; $display("FAIL roll_running: got %0b expected 1", o_running); end
    pulse(1, 0, 0);
    pulse(0, 1, 0);
    cycles(1);
  endtask

  task automatic test_reset_mid_run;
    pulse(1, 0, 0);
    cycles(7000);
    checks++; if (o_sec !== 6'd7)     begin errors++; $display("FAIL mid_pre_sec: got %0d expected 7", o_sec); end
    #2 reset = 1'b0;
    #1;
    checks++; if (o_sec !== 6'd0)     begin errors++; $display("FAIL mid_async_sec: got %0d expected 0", o_sec); end
    checks++; if (o_running !== 1'b0) begin errors++; $display("FAIL mid_async_running: got %0b expected 0", o_running); end
    checks++; if (o_mode !== 1'b0)    begin errors++; $display("FAIL mid_async_mode: got %0b expected 0", o_mode); end
    @(negedge clk);
    reset = 1'b1;
    cycles(30);
    checks++; if (o_msec !== 7'd0)    begin errors++; $display("FAIL mid_wait_msec: got %0d expected 0", o_msec); end
    checks++; if (o_running !== 1'b0) begin errors++; $display("FAIL mid_wait_running: got %0b expected 0", o_running); end
    pulse(1, 0, 0);
    cycles(10);
    checks++; if (o_msec !== 7'd1)    begin errors++; $display("FAIL mid_restart_msec: got %0d expected 1", o_msec); end
  endtask

  initial begin
    reset          = 1'b0;
    i_btn_run_stop = 1'b0;
    i_btn_clear    = 1'b0;
    i_btn_run_md   = 1'b0;
    test_reset();
    test_run_one_second();
    test_phase_resume();
    test_clear_priority();
    test_mode();
    test_rollover();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_control.md
STOPWATCH_CONTROL -- requirements
Module: stopwatch_control

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 100, centisecond tick rate in Hz; DIV = CLK_FREQ/TICK_HZ, DIV >= 2.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; reset=0 forces reset state immediately, release synchronous to clk.
REQ-005 i_btn_run_stop  input  1  one-cycle pulse from debounced run/stop button.
REQ-006 i_btn_clear  input  1  one-cycle pulse from debounced clear button.
REQ-007 i_btn_run_md  input  1  one-cycle pulse from debounced mode button.
REQ-008 o_msec  output  7  centiseconds 0..99.
REQ-009 o_sec  output  6  seconds 0..59.
REQ-010 o_min  output  6  minutes 0..59.
REQ-011 o_hour  output  5  hours 0..23.
REQ-012 o_running  output  1  high while FSM in RUN.
REQ-013 o_mode  output  1  display mode: 0 = sec/msec view, 1 = hour/min view.

Function
REQ-014 FSM states STOP, RUN, CLEAR; all outputs registered.
REQ-015 STOP: i_btn_clear -> CLEAR; else i_btn_run_stop -> RUN; else stay.
REQ-016 STOP with i_btn_clear and i_btn_run_stop in same cycle: clear wins, run_stop discarded.
REQ-017 RUN: i_btn_run_stop -> STOP; i_btn_clear ignored in RUN.
REQ-018 CLEAR: lasts exactly one cycle; zeroes all counters and prescaler; next state STOP unconditionally; button pulses during CLEAR ignored.
REQ-019 o_running = 1 in the cycle after the RUN transition edge, through the last RUN cycle; 0 otherwise.
REQ-020 Prescaler counts 0..DIV-1 only in RUN; wraps to 0 and asserts internal tick on the cycle it holds DIV-1.
REQ-021 Prescaler holds its value in STOP (resume keeps sub-tick phase); zeroed only by CLEAR or reset.
REQ-022 On tick: o_msec increments; at 99 wraps to 0 and carries to o_sec in the same cycle.
REQ-023 o_sec 59->0 carries to o_min; o_min 59->0 carries to o_hour; o_hour 23->0 with no further carry; all cascaded carries occur in the same clock edge.
REQ-024 Counters never hold out-of-range values; no saturation, wrap only.
REQ-025 RUN->STOP on the same cycle a tick would occur: tick is still applied (prescaler wraps, counters advance) on that edge.
REQ-026 i_btn_run_md toggles o_mode on the following edge in any state, including CLEAR, simultaneous with other buttons; CLEAR does not alter o_mode.
REQ-027 Counter values hold unchanged in STOP.

Reset
REQ-028 reset=0: state STOP, prescaler 0, o_msec/o_sec/o_min/o_hour = 0, o_running = 0, o_mode = 0, asynchronously.
REQ-029 reset asserted mid-RUN discards all progress; after release the block waits in STOP for i_btn_run_stop.
REQ-030 Button pulses coincident with the reset-release edge are ignored.

Verification (CLK_FREQ=1000, TICK_HZ=100, DIV=10)
REQ-031 Reset, pulse run_stop, run 1000 cycles -> o_running=1, o_sec=1, o_msec=0 (±1 tick for entry latency, checked exactly by model).
REQ-032 Preload via run to 23:59:59.99, one more tick -> all counters 0 in a single edge.
REQ-033 Run 25 cycles, run_stop, wait 500, run_stop, run 5 -> o_msec=3, prescaler phase preserved (no lost/extra tick).
REQ-034 In STOP, pulse clear and run_stop same cycle -> one CLEAR cycle, counters 0, state STOP, o_running=0; clear pulse during RUN -> no effect.
REQ-035 Pulse run_md three times across STOP/RUN/CLEAR -> o_mode 1,0,1; counters unaffected.
REQ-036 Assert reset mid-RUN at o_sec=7 -> all outputs 0 immediately without a clock edge; after release, no counting until run_stop.
